// File: rtl/mouse_paddle_pkg.sv
// rtl/mouse_paddle_pkg.sv - PS/2 packet field offsets and paddle arithmetic helpers
package mouse_paddle_pkg;

   // Bit positions inside the 25-bit hps_io ps2_mouse bus
   localparam int STB_BIT = 24;
   localparam int XS_BIT  = 4;
   localparam int YS_BIT  = 5;
   localparam int X_LSB   = 8;
   localparam int Y_LSB   = 16;

   // Limit a scaled delta to +/- mx
   function automatic logic signed [31:0] clamp_step(input logic signed [31:0] v,
                                                     input int                 mx);
      if (v > mx) begin
         return mx;
      end else if (v < -mx) begin
         return -mx;
      end
      return v;
   endfunction

   // acc + d, saturated to the two's-complement range of a width-bit value.
   // Operands are small (an accumulator plus a clamped step), so 32 bits
   // cannot wrap for any width that fits the output.
   function automatic logic signed [31:0] sat_add(input logic signed [31:0] acc,
                                                  input logic signed [31:0] d,
                                                  input int                 width);
      logic signed [31:0] s;
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      s  = acc + d;
      hi = (32'sd1 <<< (width - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (width - 1));
      if (s > hi) begin
         return hi;
      end else if (s < lo) begin
         return lo;
      end
      return s;
   endfunction

endpackage

// File: rtl/mouse_axis_acc.sv
// rtl/mouse_axis_acc.sv - one paddle axis: scale, clamp, invert, saturate, decay
module mouse_axis_acc
   import mouse_paddle_pkg::*;
#(
   parameter int ACC_W    = 8,
   parameter int MAX_STEP = 10
) (
   input  logic             clk_sys,
   input  logic             reset_n,
   input  logic             sign,
   input  logic [7:0]       mag,
   input  logic [1:0]       sens,
   input  logic             inv,
   input  logic             clear,
   input  logic             pkt,
   input  logic             decay_tick,
   output logic [ACC_W-1:0] nxt
);

   logic [ACC_W-1:0]   acc;
   logic signed [31:0] raw;
   logic signed [31:0] sh;
   logic signed [31:0] cl;
   logic signed [31:0] d;
   logic signed [31:0] acc_ext;
   logic [ACC_W-1:0]   pkt_val;
   logic [ACC_W-1:0]   dec_val;

   // Delta path is evaluated wider than the accumulator, so negating
   // -MAX_STEP and adding to the range limits never wraps before saturation.
   assign raw     = {{23{sign}}, sign, mag};
   assign sh      = raw >>> sens;
   assign cl      = clamp_step(sh, MAX_STEP);
   assign d       = inv ? -cl : cl;
   assign acc_ext = {{(32 - ACC_W){acc[ACC_W-1]}}, acc};
   assign pkt_val = ACC_W'(sat_add(acc_ext, d, ACC_W));

   // One step toward zero; zero stays put
   assign dec_val = (acc == '0) ? acc :
                    (acc[ACC_W-1] ? acc + ACC_W'(1) : acc - ACC_W'(1));

   // Next accumulator value: clear beats packet beats decay
   always_comb begin
      nxt = acc;
      if (clear) begin
         nxt = '0;
      end else if (pkt) begin
         nxt = pkt_val;
      end else if (decay_tick) begin
         nxt = dec_val;
      end
   end

   // Accumulator register
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         acc <= '0;
      end else begin
         acc <= nxt;
      end
   end

endmodule

// File: rtl/mouse_paddle_axis.sv
// rtl/mouse_paddle_axis.sv - PS/2 mouse to paddle emulation with joystick arbitration
module mouse_paddle_axis
   import mouse_paddle_pkg::*;
#(
   parameter int ACC_W        = 8,
   parameter int MAX_STEP     = 10,
   parameter int DECAY_PERIOD = 65536
) (
   input  logic             clk_sys,
   input  logic             reset_n,
   input  logic [24:0]      ps2_mouse,
   input  logic [15:0]      joya,
   input  logic [1:0]       sens,
   input  logic             inv_x,
   input  logic             inv_y,
   input  logic             recenter,
   input  logic             decay_en,
   output logic [ACC_W-1:0] pad_x,
   output logic [ACC_W-1:0] pad_y,
   output logic [2:0]       mouse_btn,
   output logic             mouse_active
);

   localparam int             CW       = $clog2(DECAY_PERIOD);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DECAY_PERIOD - 1);

   logic             old_stb;
   logic             stb_evt;
   logic             joy_any;
   logic             clear;
   logic             decay_run;
   logic             tick;
   logic             active_nxt;
   logic [CW-1:0]    cnt;
   logic [ACC_W-1:0] nxt_x;
   logic [ACC_W-1:0] nxt_y;
   logic [ACC_W-1:0] joy_x;
   logic [ACC_W-1:0] joy_y;
   logic             unused_bits;

   // Status bits of the PS/2 header byte this block does not interpret
   assign unused_bits = ^{ps2_mouse[7:6], ps2_mouse[3]};

   // Any toggle of the strobe is a new packet
   assign stb_evt = ps2_mouse[STB_BIT] ^ old_stb;
   assign joy_any = |joya;
   assign clear   = joy_any | recenter;

   // Any stick deflection hands control back to the joystick
   assign active_nxt = joy_any ? 1'b0 : (stb_evt ? 1'b1 : mouse_active);

   assign decay_run = decay_en & mouse_active;
   assign tick      = decay_run && (cnt == CNT_LAST);

   // Fit the stick byte to the accumulator width
   generate
      if (ACC_W > 8) begin : g_joy_ext
         assign joy_x = {{(ACC_W - 8){joya[7]}}, joya[7:0]};
         assign joy_y = {{(ACC_W - 8){joya[15]}}, joya[15:8]};
      end else begin : g_joy_trunc
         assign joy_x = joya[7 -: ACC_W];
         assign joy_y = joya[15 -: ACC_W];
      end
   endgenerate

   mouse_axis_acc #(
      .ACC_W    (ACC_W),
      .MAX_STEP (MAX_STEP)
   ) u_axis_x (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .sign       (ps2_mouse[XS_BIT]),
      .mag        (ps2_mouse[X_LSB +: 8]),
      .sens       (sens),
      .inv        (inv_x),
      .clear      (clear),
      .pkt        (stb_evt),
      .decay_tick (tick),
      .nxt        (nxt_x)
   );

   mouse_axis_acc #(
      .ACC_W    (ACC_W),
      .MAX_STEP (MAX_STEP)
   ) u_axis_y (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .sign       (ps2_mouse[YS_BIT]),
      .mag        (ps2_mouse[Y_LSB +: 8]),
      .sens       (sens),
      .inv        (inv_y),
      .clear      (clear),
      .pkt        (stb_evt),
      .decay_tick (tick),
      .nxt        (nxt_y)
   );

   // Strobe history; updates even when the packet is dropped
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         old_stb <= 1'b0;
      end else begin
         old_stb <= ps2_mouse[STB_BIT];
      end
   end

   // Auto-centre interval counter, parked at zero while decay is idle
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (!decay_run || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   // Source select and output registers, fed from next-state values so a
   // packet is visible one cycle after the bus changes
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         mouse_active <= 1'b0;
         pad_x        <= '0;
         pad_y        <= '0;
         mouse_btn    <= 3'b000;
      end else begin
         mouse_active <= active_nxt;
         pad_x        <= active_nxt ? nxt_x : joy_x;
         pad_y        <= active_nxt ? nxt_y : joy_y;
         mouse_btn    <= active_nxt ? ps2_mouse[2:0] : 3'b000;
      end
   end

endmodule

// File: doc/mouse_paddle_axis.md
Name: mouse_paddle_axis

Overview:
- Converts PS/2 mouse motion packets into two saturating paddle-position accumulators (X, Y).
- Arbitrates per frame between mouse emulation and the analog joystick, so paddle games work with either device.
- Successor to the fixed 8-bit, ±10-step, shift-by-1 mouse-to-paddle logic in the core top level. Adds:
  - parametrised width, step clamp and sensitivity;
  - per-axis inversion;
  - an explicit recenter command;
  - optional auto-return-to-centre decay.
- Sits between hps_io and the console core's paddle inputs.

Parameters:
- ACC_W, 8: accumulator/output width, two's complement; range −2^(ACC_W−1) .. 2^(ACC_W−1)−1.
- MAX_STEP, 10: maximum magnitude of one packet's scaled delta, applied after shifting.
- DECAY_PERIOD, 65536: clk_sys cycles between auto-centre steps; must be ≥2.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ps2_mouse  in  25  packet bus:
  - [24] toggle strobe; [2:0] buttons; [4] X sign; [5] Y sign;
  - [15:8] X magnitude byte; [23:16] Y magnitude byte.
- joya  in  16  analog stick: [7:0] X, [15:8] Y, two's complement.
- sens  in  2  arithmetic right-shift applied to each raw 9-bit delta (0..3).
- inv_x  in  1  negate X delta before accumulation.
- inv_y  in  1  negate Y delta before accumulation.
- recenter  in  1  level; while high, both accumulators are forced to 0.
- decay_en  in  1  enable auto-return-to-centre.
- pad_x  out  ACC_W  selected X position.
- pad_y  out  ACC_W  selected Y position.
- mouse_btn  out  3  ps2_mouse[2:0] when mouse_active, else 0.
- mouse_active  out  1  1 = mouse source selected.

Behaviour:
- Reset (reset_n low, asynchronous): acc_x = acc_y = 0, mouse_active = 0, stored strobe = 0, decay counter = 0. All outputs read 0.
- Strobe:
  - Register old_stb <= ps2_mouse[24] every cycle.
  - A packet event occurs on any edge where ps2_mouse[24] != old_stb (either toggle direction).
  - The first packet after reset is accepted only if bit 24 differs from 0.
- Per-axis delta pipeline, combinational, all arithmetic at ACC_W+2 bits signed:
  1. raw = {sign, mag[7:0]} as 9-bit signed, sign-extended.
  2. sh = raw >>> sens.
  3. cl = clamp(sh, −MAX_STEP, +MAX_STEP).
  4. d = inv ? −cl : cl.
  5. nxt = acc + d, saturated to the ACC_W range.
- Packet event updates, at the same clk_sys edge:
  - acc_x <= nxt_x, acc_y <= nxt_y, mouse_active <= 1.
  - Outputs reflect a packet one cycle after ps2_mouse changes.
- Analog override:
  - If joya != 0 on an edge: mouse_active <= 0 and acc_x = acc_y <= 0.
  - This overrides a simultaneous packet event. The packet is dropped, but old_stb still updates.
- Recenter:
  - While recenter = 1: acc_x = acc_y <= 0.
  - Overrides packets and decay; mouse_active is unchanged.
  - Priority order: analog override > recenter > packet > decay.
- Decay:
  - Counter runs only while decay_en = 1 and mouse_active = 1; otherwise it holds at 0.
  - On reaching DECAY_PERIOD−1 it wraps to 0 and emits a one-cycle tick.
  - On a tick, each nonzero accumulator moves 1 toward 0; a zero accumulator stays 0.
  - A tick coinciding with a packet event is discarded (the packet wins); the counter still wraps.
- Output select (registered mux):
  - pad_x = mouse_active ? acc_x : joya[ACC_W−1:0] sign-adjusted to ACC_W.
  - Width rule for joya: if ACC_W > 8, sign-extend joya byte; if ACC_W < 8, take the top ACC_W bits.
  - pad_y likewise from joya[15:8].
  - Outputs lag inputs by one cycle.
- Saturation boundaries, at ACC_W = 8:
  - acc = 127 and d = +10 → 127.
  - acc = −128 and d = −10 → −128.
  - −MAX_STEP negation under inversion cannot overflow because of the ACC_W+2 intermediate width.

Decomposition:
- Package mouse_paddle_pkg holds:
  - PS/2 field offset constants: STB_BIT = 24, XS_BIT = 4, YS_BIT = 5, X_LSB = 8, Y_LSB = 16;
  - function sat_add(acc, d, width);
  - function clamp_step(v, max).
- Natural sub-module: mouse_axis_acc (one axis). It contains the shift, clamp, invert, saturate and decay-step logic and its accumulator register. It is instantiated twice.
- The top level holds the strobe detector, decay counter, source arbitration and output mux.

Test Plan:
- Reset, then toggle bit 24 with X = +5 (sign 0, mag 0x05), sens = 0 → next cycle pad_x = 5, mouse_active = 1, pad_y = 0.
- 20 packets of X mag 0x40 (+64) with sens = 0 → each step clamped to +10; after 13 packets pad_x = 127, and it stays 127.
- Y sign 1, mag 0xEC (−20), sens = 1, inv_y = 1 → delta −10 → +10 after inversion; pad_y = 10.
- With pad_x = 40, set joya = 16'h0030 on the same cycle as a packet toggle → next cycle mouse_active = 0, pad_x = 0x30; the accumulator reads 0 on the next mouse packet (pad_x = that packet's delta).
- DECAY_PERIOD = 4, decay_en = 1, pad_x = 3, pad_y = −2 → after 8 cycles pad_x = 1, pad_y = 0; after 12 more cycles pad_x = 0.
- Assert reset_n low mid-stream with pad_x = 50 → outputs are 0 immediately (asynchronously); after release, the first toggle to bit 24 = 1 is accepted.
